// File: rtl/rfdc_pkg.sv
// Shared constants and types for the RFDC ADC capture path.
//   SAMPLE_W / SAMPLES_PER_WORD / WORD_W : ADC stream word layout
//   TS_W                                 : system timestamp width
//   capture_state_t                      : capture controller states
package rfdc_pkg;
  localparam int SAMPLE_W         = 16;
  localparam int SAMPLES_PER_WORD = 16;
  localparam int WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;
  localparam int TS_W             = 64;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    READOUT
  } capture_state_t;
endpackage

// File: rtl/rfdc_adc_capture_if.sv
// AXI-Stream bundle used for both the ADC input and the readout output.
//   tdata  : one WORD_W word (16 signed 16-bit samples, sample 0 in [15:0])
//   tvalid : word valid
//   tready : sink ready
//   tlast  : final word of a packet (unused on the ADC input)
// master drives data/valid/last, slave drives ready.
interface rfdc_adc_capture_if;
  import rfdc_pkg::*;

  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/rfdc_capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port with a
// registered (1-cycle) read.  Written so that it maps onto block RAM.
//   clk      : clock
//   wr_en    : write strobe, wr_addr / wr_data
//   rd_en    : read strobe, rd_addr; rd_data valid the cycle after rd_en
module rfdc_capture_ram
  import rfdc_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/rfdc_adc_capture.sv
// Timestamp-triggered capture buffer for the RFDC ADC stream.  Once armed,
// the first valid ADC word at or after start_time is stored at address 0,
// followed by the next len-1 valid words; the buffer is then replayed on
// m_axis with tlast on the final word.
//   clk, reset        : clock, asynchronous active-high reset
//   s_axis_data       : ADC input stream (never stalled)
//   timestamp         : free-running system time in clk cycles
//   arm / start_time / capture_len : start a capture (IDLE only)
//   abort             : return to IDLE from any state
//   m_axis            : readout stream
//   busy, done, late, len_err, gap_count, trig_time : status
module rfdc_adc_capture
  import rfdc_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  rfdc_adc_capture_if.slave   s_axis_data,
  input  logic [TS_W-1:0]     timestamp,
  input  logic                arm,
  input  logic [TS_W-1:0]     start_time,
  input  logic [ADDR_W:0]     capture_len,
  input  logic                abort,
  rfdc_adc_capture_if.master  m_axis,
  output logic                busy,
  output logic                done,
  output logic                late,
  output logic                len_err,
  output logic [15:0]         gap_count,
  output logic [TS_W-1:0]     trig_time
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  capture_state_t    state, state_nxt;
  logic [TS_W-1:0]   start_q;
  logic [ADDR_W:0]   len_q, last_idx, rd_ptr;
  logic [ADDR_W-1:0] wr_ptr, wr_addr;
  logic              tready_q, len_ok, arm_ok, arm_bad;
  logic              trig, cap_beat, cap_last, wr_en;
  logic              rd_en, hs, final_hs;
  logic [1:0]        occ;
  logic              vld_p1, last_p1;
  logic [WORD_W-1:0] data_p1;
  logic              vld_p2, last_p2;
  logic [WORD_W-1:0] data_p2;
  logic              skid_vld, skid_last;
  logic [WORD_W-1:0] skid_data;

  assign len_ok   = (capture_len != '0) && (capture_len <= DEPTH_L);
  assign arm_ok   = (state == IDLE) && arm && !abort && len_ok;
  assign arm_bad  = (state == IDLE) && arm && !abort && !len_ok;
  assign trig     = (state == ARMED) && s_axis_data.tvalid &&
                    (timestamp >= start_q) && !abort;
  assign cap_beat = (state == CAPTURE) && s_axis_data.tvalid && !abort;
  assign last_idx = len_q - (ADDR_W+1)'(1);
  assign cap_last = cap_beat && ({1'b0, wr_ptr} == last_idx);
  assign wr_en    = trig || cap_beat;
  assign wr_addr  = trig ? '0 : wr_ptr;

  // Readout credit: at most two words (output + skid) may be held or in
  // flight, so a read is issued only when one slot is free after this cycle.
  assign hs       = vld_p2 && m_axis.tready;
  assign final_hs = (state == READOUT) && hs && last_p2 && !abort;
  assign occ      = 2'(vld_p2) + 2'(skid_vld) + 2'(vld_p1);
  assign rd_en    = (state == READOUT) && !abort && (rd_ptr < len_q) &&
                    ((occ != 2'd2) || hs);

  rfdc_capture_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (s_axis_data.tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (data_p1)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm_ok) state_nxt = ARMED;
      ARMED:   if (trig) state_nxt = (len_q == (ADDR_W+1)'(1)) ? READOUT : CAPTURE;
      CAPTURE: if (cap_last) state_nxt = READOUT;
      READOUT: if (final_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Control and capture state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tready_q  <= 1'b0;
      start_q   <= '0;
      len_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      gap_count <= '0;
      late      <= 1'b0;
      trig_time <= '0;
      len_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tready_q <= 1'b1;
      len_err  <= arm_bad;
      done     <= final_hs;
      if (arm_ok) begin
        start_q   <= start_time;
        len_q     <= capture_len;
        late      <= 1'b0;
        gap_count <= '0;
      end
      if (trig) begin
        trig_time <= timestamp;
        wr_ptr    <= ADDR_W'(1);
        if (timestamp != start_q) late <= 1'b1;
      end else if (cap_beat) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if ((state == CAPTURE) && !s_axis_data.tvalid && !abort)
        gap_count <= sat_inc(gap_count);
      if (state != READOUT) rd_ptr <= '0;
      else if (rd_en)       rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
    end
  end

  // Stage p1: RAM read in flight; p2: output register with skid behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      vld_p2    <= 1'b0;
      last_p2   <= 1'b0;
      data_p2   <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
    end else begin
      vld_p1  <= rd_en;
      last_p1 <= (rd_ptr == last_idx);
      if (abort) begin
        vld_p2   <= 1'b0;
        skid_vld <= 1'b0;
      end else if (!vld_p2 || hs) begin
        if (skid_vld) begin
          vld_p2    <= 1'b1;
          data_p2   <= skid_data;
          last_p2   <= skid_last;
          skid_vld  <= vld_p1;
          skid_last <= last_p1;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) begin
            data_p2 <= data_p1;
            last_p2 <= last_p1;
          end
        end
      end else if (vld_p1) begin
        skid_vld  <= 1'b1;
        skid_last <= last_p1;
      end
    end
  end

  // Skid data follows the same load decisions as skid_vld
  always_ff @(posedge clk) begin
    if (vld_p1 && !abort && ((skid_vld && (!vld_p2 || hs)) || (vld_p2 && !hs)))
      skid_data <= data_p1;
  end

  assign s_axis_data.tready = tready_q;
  assign m_axis.tvalid      = vld_p2;
  assign m_axis.tdata       = data_p2;
  assign m_axis.tlast       = last_p2;
  assign busy               = (state != IDLE);
endmodule

// File: tb/tb_rfdc_adc_capture.sv
module tb_rfdc_adc_capture;
  import rfdc_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef struct {
    logic [63:0] arm_ts;
    logic [63:0] start;
    int          len;
    logic [63:0] exp_trig;
    logic        exp_late;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [63:0]     ts = 64'd0;
  logic            arm = 1'b0;
  logic            abort = 1'b0;
  logic [63:0]     start_time = 64'd0;
  logic [ADDR_W:0] capture_len = '0;
  logic            busy, done, late, len_err;
  logic [15:0]     gap_count;
  logic [63:0]     trig_time;
  logic [63:0]     g0 = '1, g1 = '1, g2 = '1;
  logic            m_ready = 1'b0;
  logic [15:0]     exp_w [DEPTH];
  int              errors = 0;
  int              checks = 0;
  vec_t            tbl [4];

  rfdc_adc_capture_if s_if ();
  rfdc_adc_capture_if m_if ();

  assign s_if.tdata  = {SAMPLES_PER_WORD{ts[15:0]}};
  assign s_if.tvalid = !((ts == g0) || (ts == g1) || (ts == g2));
  assign s_if.tlast  = 1'b0;
  assign m_if.tready = m_ready;

  rfdc_adc_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis_data (s_if),
    .timestamp   (ts),
    .arm         (arm),
    .start_time  (start_time),
    .capture_len (capture_len),
    .abort       (abort),
    .m_axis      (m_if),
    .busy        (busy),
    .done        (done),
    .late        (late),
    .len_err     (len_err),
    .gap_count   (gap_count),
    .trig_time   (trig_time)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts <= ts + 64'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at ts=%0d", name, ts);
  endtask

  task automatic wait_ts(input logic [63:0] t);
    int n = 0;
    while (ts != t && n < 3000) begin
      step();
      n++;
    end
    if (ts != t) timeout("wait_ts");
  endtask

  task automatic collect(input int n, input bit rnd);
    int idx = 0;
    int cyc = 0;
    logic [WORD_W:0] exp_word;
    while (idx < n && cyc < 4000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_if.tvalid && m_ready) begin
        exp_word = {(idx == n - 1), {SAMPLES_PER_WORD{exp_w[idx]}}};
        checks++;
        if ({m_if.tlast, m_if.tdata} !== exp_word) begin
          errors++;
          $display("FAIL word%0d: got last=%0b data=%0h expected last=%0b data=%0h",
                   idx, m_if.tlast, m_if.tdata, exp_word[WORD_W], exp_word[WORD_W-1:0]);
        end
        idx++;
      end
      step();
      cyc++;
    end
    if (idx < n) timeout("readout");
    else begin
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_end", 64'(busy), 64'd0);
    end
    m_ready = 1'b0;
  endtask

  task automatic run_cap(input logic [63:0] arm_ts, input logic [63:0] start, input int len,
                         input bit rnd, input logic [63:0] exp_trig, input logic exp_late,
                         input logic [15:0] exp_gap);
    wait_ts(arm_ts);
    arm = 1'b1;
    start_time = start;
    capture_len = (ADDR_W+1)'(len);
    step();
    arm = 1'b0;
    chk("busy_armed", 64'(busy), 64'd1);
    collect(len, rnd);
    chk("trig_time", trig_time, exp_trig);
    chk("late", 64'(late), 64'(exp_late));
    chk("gap_count", 64'(gap_count), 64'(exp_gap));
  endtask

  task automatic chk_reset_vals();
    chk("rst_flags", 64'({m_if.tvalid, m_if.tlast, busy, done, late, len_err, s_if.tready}), 64'd0);
    chk("rst_gap", 64'(gap_count), 64'd0);
    chk("rst_trig", trig_time, 64'd0);
    chk("rst_tdata", 64'(m_if.tdata != '0), 64'd0);
  endtask

  initial begin
    logic done_seen;
    int n;

    tbl[0] = '{arm_ts: 64'd200,  start: 64'd50,   len: 3, exp_trig: 64'd201,  exp_late: 1'b1};
    tbl[1] = '{arm_ts: 64'd990,  start: 64'd1000, len: 4, exp_trig: 64'd1000, exp_late: 1'b0};
    tbl[2] = '{arm_ts: 64'd1100, start: 64'd1105, len: 1, exp_trig: 64'd1105, exp_late: 1'b0};
    tbl[3] = '{arm_ts: 64'd1200, start: 64'd1200, len: 2, exp_trig: 64'd1201, exp_late: 1'b1};

    // power-on reset
    step();
    step();
    chk_reset_vals();
    reset = 1'b0;
    chk("tready_at_release", 64'(s_if.tready), 64'd0);
    step();
    chk("tready_after_clk", 64'(s_if.tready), 64'd1);

    // table-driven captures with continuous ADC data
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < tbl[v].len; i++) exp_w[i] = 16'(tbl[v].exp_trig + 64'(i));
      run_cap(tbl[v].arm_ts, tbl[v].start, tbl[v].len, 1'b0, tbl[v].exp_trig, tbl[v].exp_late, 16'd0);
    end

    // ADC gaps mid-capture
    g0 = 64'd1312;
    g1 = 64'd1313;
    g2 = 64'd1315;
    exp_w[0] = 16'd1310; exp_w[1] = 16'd1311; exp_w[2] = 16'd1314; exp_w[3] = 16'd1316;
    exp_w[4] = 16'd1317; exp_w[5] = 16'd1318; exp_w[6] = 16'd1319; exp_w[7] = 16'd1320;
    run_cap(64'd1300, 64'd1310, 8, 1'b0, 64'd1310, 1'b0, 16'd3);
    g0 = '1;
    g1 = '1;
    g2 = '1;

    // full-depth capture with random readout backpressure
    for (int i = 0; i < DEPTH; i++) exp_w[i] = 16'(1510 + i);
    run_cap(64'd1500, 64'd1510, DEPTH, 1'b1, 64'd1510, 1'b0, 16'd0);

    // invalid lengths
    step();
    arm = 1'b1;
    capture_len = '0;
    start_time = ts + 64'd10;
    step();
    arm = 1'b0;
    chk("len0_err", 64'(len_err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    step();
    chk("len_err_pulse", 64'(len_err), 64'd0);
    arm = 1'b1;
    capture_len = (ADDR_W+1)'(DEPTH + 1);
    step();
    arm = 1'b0;
    chk("lenbig_err", 64'(len_err), 64'd1);
    chk("lenbig_busy", 64'(busy), 64'd0);

    // abort during READOUT with a simultaneous arm
    wait_ts(64'd1900);
    arm = 1'b1;
    start_time = 64'd1905;
    capture_len = (ADDR_W+1)'(8);
    step();
    arm = 1'b0;
    m_ready = 1'b0;
    n = 0;
    while (!m_if.tvalid && n < 50) begin
      step();
      n++;
    end
    if (!m_if.tvalid) timeout("abort_wait_tvalid");
    abort = 1'b1;
    arm = 1'b1;
    capture_len = (ADDR_W+1)'(4);
    start_time = ts;
    step();
    abort = 1'b0;
    arm = 1'b0;
    done_seen = done;
    chk("abort_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    abort = 1'b1;
    arm = 1'b1;
    step();
    abort = 1'b0;
    arm = 1'b0;
    done_seen = done_seen | done;
    chk("arm_with_abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      done_seen = done_seen | done;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    // reset in the middle of a capture
    wait_ts(64'd2000);
    arm = 1'b1;
    start_time = 64'd2005;
    capture_len = (ADDR_W+1)'(16);
    step();
    arm = 1'b0;
    wait_ts(64'd2008);
    chk("busy_mid_capture", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    step();
    step();
    reset = 1'b0;
    step();
    chk("tready_after_reset", 64'(s_if.tready), 64'd1);
    exp_w[0] = 16'd2035;
    exp_w[1] = 16'd2036;
    run_cap(64'd2030, 64'd2035, 2, 1'b0, 64'd2035, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
